// File: rtl/clkspec_arith_pkg.sv
// Shared definitions for the iterative divider: FSM states and the
// width-independent helpers used for the divide-by-zero and sign fix-up.
package clkspec_arith_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_t;

  // Helpers work on the widest legal operand; callers slice the low bits.
  localparam int MAX_W = 64;

  // All-ones quotient reported for a zero divisor, w bits wide.
  function automatic logic [MAX_W-1:0] dz_quo(input int w);
    logic [MAX_W-1:0] ones;
    ones = '1;
    return ones >> (MAX_W - w);
  endfunction

  // Two's-complement negate when neg is set; the low bits of the result
  // are correct for any narrower width, which doubles as abs().
  function automatic logic [MAX_W-1:0] cond_neg(input logic [MAX_W-1:0] x,
                                                input logic neg);
    return neg ? (~x + 64'd1) : x;
  endfunction

endpackage

// File: rtl/clkspec_divmod_step.sv
// One restoring-division iteration: shift the remainder/dividend pair left,
// trial-subtract the divisor and produce one quotient bit.
module clkspec_divmod_step
  import clkspec_arith_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH:0]   prem,
  input  logic [WIDTH-1:0] dvd,
  input  logic [WIDTH-1:0] dvs,
  output logic [WIDTH:0]   prem_nxt,
  output logic [WIDTH-1:0] dvd_nxt
);

  logic [WIDTH+1:0] sh;
  logic [WIDTH+1:0] diff;
  logic             qbit;

  // Trial subtraction; a borrow out of the extra top bit means "no fit".
  always_comb begin
    sh       = {prem, dvd[WIDTH-1]};
    diff     = sh - {2'b00, dvs};
    qbit     = ~diff[WIDTH+1];
    prem_nxt = qbit ? diff[WIDTH:0] : sh[WIDTH:0];
    dvd_nxt  = {dvd[WIDTH-2:0], qbit};
  end

endmodule

// File: rtl/clkspec_divmod_n.sv
// Iterative quotient/remainder unit, one quotient bit per clock, with
// optional signed operands, divide-by-zero reporting and valid/ready ports.
module clkspec_divmod_n
  import clkspec_arith_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter bit SIGNED_EN = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dd,
  input  logic [WIDTH-1:0] dv,
  input  logic             signed_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quo,
  output logic [WIDTH-1:0] rem,
  output logic             div_zero
);

  localparam int CNT_W = $clog2(WIDTH);

  div_state_t state, state_nxt;

  logic [CNT_W-1:0] cnt;
  logic [WIDTH:0]   prem, prem_nxt;
  logic [WIDTH-1:0] dvd, dvd_nxt;
  logic [WIDTH-1:0] dvs;
  logic             neg_q, neg_r;

  logic signed [WIDTH-1:0] dd_s, dv_s;
  logic             sgn_act, dd_neg, dv_neg;
  logic [MAX_W-1:0] dd64, dv64, ddm64, dvm64;
  logic [MAX_W-1:0] q64, r64, qf64, rf64, dz64;

  clkspec_divmod_step #(.WIDTH(WIDTH)) u_step (
    .prem     (prem),
    .dvd      (dvd),
    .dvs      (dvs),
    .prem_nxt (prem_nxt),
    .dvd_nxt  (dvd_nxt)
  );

  // Operand magnitudes at accept and sign-corrected result of the last step.
  always_comb begin
    dd_s    = dd;
    dv_s    = dv;
    sgn_act = SIGNED_EN && signed_mode;
    dd_neg  = sgn_act && (dd_s < 0);
    dv_neg  = sgn_act && (dv_s < 0);
    dd64    = '0;
    dv64    = '0;
    q64     = '0;
    r64     = '0;
    dd64[WIDTH-1:0] = dd;
    dv64[WIDTH-1:0] = dv;
    q64[WIDTH-1:0]  = dvd_nxt;
    r64[WIDTH-1:0]  = prem_nxt[WIDTH-1:0];
    ddm64 = cond_neg(dd64, dd_neg);
    dvm64 = cond_neg(dv64, dv_neg);
    qf64  = cond_neg(q64, neg_q);
    rf64  = cond_neg(r64, neg_r);
    dz64  = dz_quo(WIDTH);
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state decode and handshake outputs.
  always_comb begin
    state_nxt = state;
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
    case (state)
      IDLE:    if (in_valid) state_nxt = (dv == '0) ? DONE : CALC;
      CALC:    if (cnt == '0) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operand capture, iteration and result registration on DONE entry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt      <= '0;
      prem     <= '0;
      dvd      <= '0;
      dvs      <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      quo      <= '0;
      rem      <= '0;
      div_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            prem  <= '0;
            dvd   <= ddm64[WIDTH-1:0];
            dvs   <= dvm64[WIDTH-1:0];
            neg_q <= dd_neg ^ dv_neg;
            neg_r <= dd_neg;
            cnt   <= CNT_W'(WIDTH - 1);
            if (dv == '0) begin
              quo      <= dz64[WIDTH-1:0];
              rem      <= dd;
              div_zero <= 1'b1;
            end
          end
        end
        CALC: begin
          prem <= prem_nxt;
          dvd  <= dvd_nxt;
          if (cnt == '0) begin
            quo      <= qf64[WIDTH-1:0];
            rem      <= rf64[WIDTH-1:0];
            div_zero <= 1'b0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_clkspec_divmod_n.sv
// Bench for clkspec_divmod_n (WIDTH=16): directed vector table, hand-written
// backpressure and mid-operation reset sequences, and random operations
// checked against an arithmetic reference model.
module tb_clkspec_divmod_n;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] dd = '0;
  logic [W-1:0] dv = '0;
  logic         signed_mode = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] quo;
  logic [W-1:0] rem;
  logic         div_zero;

  int passed = 0;
  int total  = 0;

  clkspec_divmod_n #(.WIDTH(W), .SIGNED_EN(1'b1)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dd          (dd),
    .dv          (dv),
    .signed_mode (signed_mode),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quo         (quo),
    .rem         (rem),
    .div_zero    (div_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    bit           sm;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         z;
    int           lat;
  } vec_t;

  vec_t tbl[9];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  // Reference: plain integer division semantics (C-style truncation).
  function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b, input bit sm,
                                output logic [W-1:0] q, output logic [W-1:0] r, output logic z);
    int sa, sb, iq, ir;
    if (b == 0) begin
      q = '1; r = a; z = 1'b1;
    end else if (sm) begin
      sa = int'($signed(a));
      sb = int'($signed(b));
      iq = sa / sb;
      ir = sa % sb;
      q = iq[W-1:0]; r = ir[W-1:0]; z = 1'b0;
    end else begin
      q = a / b; r = a % b; z = 1'b0;
    end
  endfunction

  // Issue one operation; lat counts rising edges from the accept edge
  // (inclusive) until out_valid is seen.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input bit sm,
                       output logic [W-1:0] q, output logic [W-1:0] r,
                       output logic z, output int lat);
    @(negedge clk);
    dd = a; dv = b; signed_mode = sm; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    q = quo; r = rem; z = div_zero;
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  initial begin
    logic [W-1:0] q, r, eq, er, a, b;
    logic         z, ez;
    bit           sm;
    int           lat;

    tbl[0] = '{16'd100,   16'd7,      1'b0, 16'd14,    16'd2,     1'b0, 17};
    tbl[1] = '{16'hFFF9,  16'd2,      1'b1, 16'hFFFD,  16'hFFFF,  1'b0, 17};
    tbl[2] = '{16'd7,     16'hFFFE,   1'b1, 16'hFFFD,  16'd1,     1'b0, 17};
    tbl[3] = '{16'd1234,  16'd0,      1'b0, 16'hFFFF,  16'd1234,  1'b1, 1};
    tbl[4] = '{16'd9,     16'd3,      1'b0, 16'd3,     16'd0,     1'b0, 17};
    tbl[5] = '{16'h8000,  16'hFFFF,   1'b1, 16'h8000,  16'd0,     1'b0, 17};
    tbl[6] = '{16'hFFFF,  16'd1,      1'b0, 16'hFFFF,  16'd0,     1'b0, 17};
    tbl[7] = '{16'h8000,  16'hFFFF,   1'b0, 16'd0,     16'h8000,  1'b0, 17};
    tbl[8] = '{16'hFFF0,  16'd0,      1'b1, 16'hFFFF,  16'hFFF0,  1'b1, 1};

    // Reset state, observed while reset is held.
    #3;
    check("rst_quo", 32'(quo), 32'd0);
    check("rst_rem", 32'(rem), 32'd0);
    check("rst_dz", 32'(div_zero), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk); reset = 1'b0;
    @(negedge clk);

    // Directed vectors.
    foreach (tbl[i]) begin
      do_op(tbl[i].a, tbl[i].b, tbl[i].sm, q, r, z, lat);
      check($sformatf("vec%0d_quo", i), 32'(q), 32'(tbl[i].q));
      check($sformatf("vec%0d_rem", i), 32'(r), 32'(tbl[i].r));
      check($sformatf("vec%0d_dz", i), 32'(z), 32'(tbl[i].z));
      check($sformatf("vec%0d_lat", i), 32'(lat), 32'(tbl[i].lat));
    end

    // Backpressure: result holds, input side stays closed, stray in_valid ignored.
    @(negedge clk);
    dd = 16'd200; dv = 16'd9; signed_mode = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    check("bp_lat", 32'(lat), 32'd17);
    check("bp_quo", 32'(quo), 32'd22);
    check("bp_rem", 32'(rem), 32'd2);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = (i == 2);
      dd = 16'd5; dv = 16'd1;
      @(posedge clk); #1;
      check("bp_hold_quo", 32'(quo), 32'd22);
      check("bp_hold_rem", 32'(rem), 32'd2);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_out_valid", 32'(out_valid), 32'd1);
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("bp_release_in_ready", 32'(in_ready), 32'd1);
    check("bp_release_out_valid", 32'(out_valid), 32'd0);
    check("bp_after_quo", 32'(quo), 32'd22);
    repeat (3) begin
      @(posedge clk); #1;
      check("bp_no_phantom_op", 32'(out_valid), 32'd0);
    end

    // Reset five cycles into an operation abandons it.
    @(negedge clk);
    dd = 16'd1000; dv = 16'd3; signed_mode = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("mid_busy_in_ready", 32'(in_ready), 32'd0);
    repeat (4) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_quo", 32'(quo), 32'd0);
    check("mid_rst_rem", 32'(rem), 32'd0);
    check("mid_rst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk); reset = 1'b0;
    do_op(16'd50, 16'd5, 1'b0, q, r, z, lat);
    check("post_rst_quo", 32'(q), 32'd10);
    check("post_rst_rem", 32'(r), 32'd0);
    check("post_rst_lat", 32'(lat), 32'd17);

    // Random operations against the reference model.
    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 7))
        0:       b = '0;
        1:       b = 16'd1;
        2:       b = 16'hFFFF;
        3:       b = 16'($urandom_range(1, 15));
        default: b = 16'($urandom);
      endcase
      a  = ($urandom_range(0, 5) == 0) ? 16'h8000 : 16'($urandom);
      sm = 1'($urandom);
      model(a, b, sm, eq, er, ez);
      do_op(a, b, sm, q, r, z, lat);
      check($sformatf("rnd%0d_quo", n), 32'(q), 32'(eq));
      check($sformatf("rnd%0d_rem", n), 32'(r), 32'(er));
      check($sformatf("rnd%0d_dz", n), 32'(z), 32'(ez));
      check($sformatf("rnd%0d_lat", n), 32'(lat), (b == 0) ? 32'd1 : 32'd17);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
